// File: rtl/mem_byte_bridge.sv
// Splits core loads/stores into little-endian byte beats on an 8-bit memory bus.
// Optional per-beat bus_ready timeout is built in when BUS_TIMEOUT_EN is defined.
module mem_byte_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WAIT_STATES    = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memory_read,
  input  logic                  memory_write,
  input  logic [2:0]            option,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  memory_response,
  output logic                  bus_error,
  output logic                  bus_valid,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ready
);

  // state | meaning
  // IDLE  | waiting for memory_read / memory_write
  // WAIT  | wait-state countdown before a beat, bus_valid low
  // BEAT  | bus_valid high, waiting for bus_ready
  // DONE  | one-cycle memory_response, requests not sampled
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE} state_t;

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(NB);
  localparam int WW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
`ifdef BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  state_t                  r_state, w_state_nxt;
  logic                    r_we;
  logic [2:0]              r_opt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [NB-1:0][7:0]      r_wdata;
  logic [NB-1:0][7:0]      r_rbuf;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           r_last;
  logic [WW-1:0]           r_wcnt;
  logic [TW-1:0]           r_tcnt;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;

  logic                    w_req;
  logic                    w_last;
  logic                    w_tmo_hit;
  logic [IW-1:0]           w_last_req;
  logic [NB-1:0][7:0]      w_rbuf;
  logic [DATA_WIDTH-1:0]   w_ext;

  assign w_req  = memory_read | memory_write;
  assign w_last = (r_idx == r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tmo_hit       = 1'b0;
    memory_response = 1'b0;
    bus_valid       = 1'b0;
    bus_we          = 1'b0;
    bus_addr        = '0;
    bus_wdata       = '0;
    case (r_state)
      S_IDLE: if (w_req) w_state_nxt = HAS_WAIT ? S_WAIT : S_BEAT;
      S_WAIT: if (r_wcnt == '0) w_state_nxt = S_BEAT;
      S_BEAT: begin
        bus_valid = 1'b1;
        bus_we    = r_we;
        bus_addr  = r_addr + ADDR_WIDTH'(r_idx);
        bus_wdata = r_wdata[r_idx];
        if (bus_ready) begin
          if (w_last)        w_state_nxt = S_DONE;
          else if (HAS_WAIT) w_state_nxt = S_WAIT;
          else               w_state_nxt = S_BEAT;
        end else if (TMO_EN && (r_tcnt == '0)) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        memory_response = 1'b1;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (option)
      3'b000, 3'b100: w_last_req = '0;
      3'b001, 3'b101: w_last_req = IW'(1);
      3'b010:         w_last_req = IW'(3);
      default:        w_last_req = IW'(NB - 1);
    endcase
  end

  // Read buffer including the byte arriving this cycle, so read_data is valid in DONE.
  always_comb begin
    w_rbuf = r_rbuf;
    if (r_state == S_BEAT) w_rbuf[r_idx] = bus_rdata;
    case (r_opt)
      3'b000:  w_ext = {{(DATA_WIDTH-8){w_rbuf[0][7]}}, w_rbuf[0]};
      3'b100:  w_ext = DATA_WIDTH'(w_rbuf[0]);
      3'b001:  w_ext = {{(DATA_WIDTH-16){w_rbuf[1][7]}}, w_rbuf[1], w_rbuf[0]};
      3'b101:  w_ext = DATA_WIDTH'({w_rbuf[1], w_rbuf[0]});
      default: w_ext = w_rbuf;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_opt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_idx   <= '0;
      r_last  <= '0;
      r_wcnt  <= '0;
      r_tcnt  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_tmo_hit;
      // Down-counters preload whenever idle so each wait period / beat starts fresh.
      if (r_state != S_WAIT)   r_wcnt <= WW'(WAIT_STATES - 1);
      else if (r_wcnt != '0)   r_wcnt <= r_wcnt - WW'(1);
      if ((r_state != S_BEAT) || bus_ready) r_tcnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (r_tcnt != '0)                r_tcnt <= r_tcnt - TW'(1);

      case (r_state)
        S_IDLE: if (w_req) begin
          r_we    <= memory_write;
          r_opt   <= option;
          r_addr  <= address;
          r_wdata <= write_data;
          r_idx   <= '0;
          r_last  <= w_last_req;
          r_rbuf  <= '0;
        end
        S_BEAT: begin
          if (bus_ready) begin
            if (!r_we) r_rbuf <= w_rbuf;
            if (!w_last) r_idx <= r_idx + IW'(1);
            else if (!r_we) r_rdata <= w_ext;
          end else if (w_tmo_hit && !r_we) begin
            r_rdata <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign read_data = r_rdata;
  assign bus_error = r_err;

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Directed bench for mem_byte_bridge: vector table on a zero-wait instance,
// hand sequences for reset abort, address wrap, wait states and timeout.
module tb_mem_byte_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        memory_read, memory_write;
  logic [2:0]  option;
  logic [31:0] address, write_data, read_data;
  logic        memory_response, bus_error, bus_valid, bus_we;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        bus_ready;

  logic        w_memory_read, w_memory_write;
  logic [2:0]  w_option;
  logic [31:0] w_address, w_write_data, w_read_data;
  logic        w_memory_response, w_bus_error, w_bus_valid, w_bus_we;
  logic [31:0] w_bus_addr;
  logic [7:0]  w_bus_wdata, w_bus_rdata;
  logic        w_bus_ready;

  mem_byte_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(0), .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .memory_read(memory_read), .memory_write(memory_write), .option(option),
    .address(address), .write_data(write_data), .read_data(read_data),
    .memory_response(memory_response), .bus_error(bus_error),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  mem_byte_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(2), .TIMEOUT_CYCLES(8)) u_dut_w (
    .clk(clk), .rst_n(rst_n),
    .memory_read(w_memory_read), .memory_write(w_memory_write), .option(w_option),
    .address(w_address), .write_data(w_write_data), .read_data(w_read_data),
    .memory_response(w_memory_response), .bus_error(w_bus_error),
    .bus_valid(w_bus_valid), .bus_we(w_bus_we), .bus_addr(w_bus_addr),
    .bus_wdata(w_bus_wdata), .bus_rdata(w_bus_rdata), .bus_ready(w_bus_ready)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  opt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rb;      // bus read bytes, beat k = rb[8k +: 8]
    int          nb;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, k;
    bit seen;
    logic [31:0] ea;
    cyc = 0; k = 0; seen = 0;
    memory_read = v.rd; memory_write = v.wr; option = v.opt;
    address = v.addr; write_data = v.wdata; bus_ready = 1'b1; bus_rdata = 8'h00;
    while (!seen && cyc < 40) begin
      @(negedge clk); cyc++;
      if (bus_valid) begin
        ea = v.addr + k;
        check("beat_cycle", cyc, k + 1);
        check("bus_addr", bus_addr, ea);
        check("bus_we", bus_we, v.wr);
        if (k < 4) begin
          if (v.wr) check("bus_wdata", bus_wdata, v.wdata[8*k +: 8]);
          bus_rdata = v.rb[8*k +: 8];
        end
        k++;
      end
      if (memory_response) begin
        seen = 1;
        check("resp_cycle", cyc, v.nb + 1);
        check("read_data", read_data, v.exp_rd);
        check("bus_error", bus_error, 1'b0);
        memory_read = 1'b0; memory_write = 1'b0;
      end
    end
    check("resp_seen", seen, 1'b1);
    check("beat_count", k, v.nb);
    @(negedge clk);
    check("resp_pulse", memory_response, 1'b0);
  endtask

  initial begin
    int cyc, k, stall, nvalid, nresp;
    bit seen;
    logic [31:0] ea, wrb;

    //              rd    wr    opt     addr          wdata         rb            nb exp_rd
    tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'h4433_2211, 4, 32'h4433_2211};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0200, 32'h0,        32'h0000_0080, 1, 32'hFFFF_FF80};
    tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0200, 32'h0,        32'h0000_0080, 1, 32'h0000_0080};
    tbl[3]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0300, 32'h0,        32'h0000_9234, 2, 32'hFFFF_9234};
    tbl[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0301, 32'h0,        32'h0000_9234, 2, 32'h0000_9234};
    tbl[5]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0007, 32'hDEAD_BEEF, 32'h0,        2, 32'h0000_9234};
    tbl[6]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,        4, 32'h0000_9234};
    tbl[7]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0020, 32'h0,        32'h0403_0201, 4, 32'h0403_0201};
    tbl[8]  = '{1'b1, 1'b1, 3'b000, 32'h0000_0040, 32'h0000_005A, 32'h0000_00FF, 1, 32'h0403_0201};
    tbl[9]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0041, 32'h0,        32'h0000_007F, 1, 32'h0000_007F};
    tbl[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0050, 32'h0,        32'h0000_7FFF, 2, 32'h0000_7FFF};
    tbl[11] = '{1'b1, 1'b0, 3'b111, 32'h0000_0030, 32'h0,        32'hA1B2_C3D4, 4, 32'hA1B2_C3D4};

    rst_n = 1'b0;
    memory_read = 0; memory_write = 0; option = 0; address = 0; write_data = 0;
    bus_rdata = 0; bus_ready = 0;
    w_memory_read = 0; w_memory_write = 0; w_option = 0; w_address = 0; w_write_data = 0;
    w_bus_rdata = 0; w_bus_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_read_data", read_data, 32'h0);
    check("rst_response", memory_response, 1'b0);
    check("rst_bus_valid", bus_valid, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_error", bus_error, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Reset during beat 2 of a word read aborts without a response.
    memory_read = 1'b1; option = 3'b010; address = 32'h500; write_data = 32'hFFFF_FFFF;
    bus_ready = 1'b1; bus_rdata = 8'h55;
    cyc = 0; k = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk); cyc++;
      if (bus_valid) begin
        if (k == 2) seen = 1;
        else k++;
      end
    end
    check("rst_reached_beat2", seen, 1'b1);
    check("rst_beat2_addr", bus_addr, 32'h502);
    rst_n = 1'b0;
    #1;
    check("arst_bus_valid", bus_valid, 1'b0);
    check("arst_bus_addr", bus_addr, 32'h0);
    check("arst_bus_we", bus_we, 1'b0);
    check("arst_bus_wdata", bus_wdata, 8'h0);
    check("arst_response", memory_response, 1'b0);
    check("arst_read_data", read_data, 32'h0);
    memory_read = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    nresp = 0;
    repeat (6) begin
      @(negedge clk);
      if (memory_response) nresp++;
    end
    check("no_resp_after_rst", nresp, 0);

    // Word write wrapping past the top of the address space.
    run_vec('{1'b0, 1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0, 4, 32'h0});

    // Two wait states per beat, bus_ready withheld for three cycles on beat 0.
    wrb = 32'hD3C2_B1A0;
    w_memory_read = 1'b1; w_option = 3'b010; w_address = 32'h80;
    cyc = 0; k = 0; stall = 0; nvalid = 0; seen = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk); cyc++;
      w_bus_ready = 1'b0;
      if (w_bus_valid) begin
        nvalid++;
        if (nvalid == 1) check("w_first_valid_cycle", cyc, 3);
        ea = 32'h80 + k;
        check("w_bus_addr", w_bus_addr, ea);
        if (k == 0 && stall < 3) stall++;
        else begin
          w_bus_ready = 1'b1;
          if (k < 4) w_bus_rdata = wrb[8*k +: 8];
          k++;
        end
      end
      if (w_memory_response) begin
        seen = 1;
        check("w_resp_cycle", cyc, 16);
        check("w_read_data", w_read_data, 32'hD3C2_B1A0);
        w_memory_read = 1'b0;
      end
    end
    check("w_resp_seen", seen, 1'b1);
    check("w_valid_cycles", nvalid, 7);
    @(negedge clk);

`ifdef BUS_TIMEOUT_EN
    // bus_ready stuck low: abort 8 cycles after beat entry with bus_error.
    memory_read = 1'b1; option = 3'b010; address = 32'h600; bus_ready = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk); cyc++;
      if (memory_response) begin
        seen = 1;
        check("tmo_resp_cycle", cyc, 9);
        check("tmo_bus_error", bus_error, 1'b1);
        check("tmo_read_data", read_data, 32'hFFFF_FFFF);
        memory_read = 1'b0;
      end
    end
    check("tmo_resp_seen", seen, 1'b1);
    @(negedge clk);
    run_vec(tbl[0]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_byte_bridge.md
Name: mem_byte_bridge

Overview:
- Parametrised successor to the top-level core/memory hookup, which ties memory_response combinationally to memory_read|memory_write.
- Sits between the Core data port and a byte-wide external memory bus, e.g. RAM reached through the uio pins.
- Splits each core access into little-endian byte beats, inserts programmable wait states and honours a bus_ready handshake.
- Returns a registered one-cycle memory_response, with RISC-V load sign/zero extension.

Parameters:
- ADDR_WIDTH, 32: width of core and bus addresses.
- DATA_WIDTH, 32: core data width; must be a multiple of 8, minimum 32.
- WAIT_STATES, 0: idle cycles inserted before every beat, with bus_valid low.
- TIMEOUT_CYCLES, 255: maximum wait on bus_ready per beat. Used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- memory_read  in  1  core load request; held by the core until memory_response
- memory_write  in  1  core store request; held by the core until memory_response
- option  in  3  RISC-V funct3 access size/sign
- address  in  ADDR_WIDTH  core byte address
- write_data  in  DATA_WIDTH  store data
- read_data  out  DATA_WIDTH  load result, extended per option
- memory_response  out  1  one-cycle completion pulse
- bus_error  out  1  high with memory_response when the access timed out
- bus_valid  out  1  beat request
- bus_we  out  1  beat is a write
- bus_addr  out  ADDR_WIDTH  beat byte address
- bus_wdata  out  8  beat write byte
- bus_rdata  in  8  beat read byte
- bus_ready  in  1  beat accepted/completed

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values: all outputs 0, read_data 0, FSM in IDLE. Reset mid-access aborts immediately; no response is issued for the aborted access.
- FSM states: IDLE, WAIT, BEAT, DONE.
- IDLE: if memory_write or memory_read is high, latch option, address, write_data and direction. Write has priority when both are high. Clear the beat index. Go to WAIT if WAIT_STATES>0, else BEAT.
- WAIT: count WAIT_STATES cycles with bus_valid=0, then go to BEAT.
- BEAT: bus_valid=1, bus_addr=latched address+index (modulo 2^ADDR_WIDTH, wraps), bus_we=direction, bus_wdata=write byte[index].
  - On bus_ready=1 (sampled at the edge), a read captures bus_rdata into byte[index].
  - After the last beat go to DONE. Otherwise increment the index and go to WAIT or BEAT.
  - Beats are back-to-back when WAIT_STATES=0 and ready is high.
- Beat count from option:
  - 000/100 (byte): 1 beat.
  - 001/101 (half): 2 beats.
  - 010 (word): 4 beats.
  - Any other code: DATA_WIDTH/8 beats, full width.
- Misaligned addresses are legal and go to consecutive addresses.
- DONE: memory_response=1 for exactly one cycle, then IDLE. Requests are not sampled in DONE. The core drops its request on the response edge, so no duplicate access occurs.
- read_data is updated on entry to DONE and held until the next accepted read.
  - 000: sign-extend byte 0. 100: zero-extend byte 0.
  - 001: sign-extend bytes 1:0. 101: zero-extend bytes 1:0.
  - Word/default: bytes concatenated little-endian.
- Writes leave read_data unchanged.
- Latency, WAIT_STATES=W, bus_ready tied high, N beats: request seen in cycle 0; memory_response in cycle 1+N*(W+1).
- Inputs are ignored outside IDLE. Changes to address, option or write_data mid-access have no effect.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With BUS_TIMEOUT_EN defined:
  - A per-beat counter runs while in BEAT with bus_ready=0.
  - When it reaches TIMEOUT_CYCLES, the access aborts: go to DONE, pulse memory_response with bus_error=1, and set read_data to all ones for a read.
  - The counter clears on every beat entry.
- Without BUS_TIMEOUT_EN: BEAT waits indefinitely and bus_error is constant 0.

Test Plan:
- Word read: WAIT_STATES=0, ready=1, address 0x100, bus returns 0x11,0x22,0x33,0x44 -> bus_addr 0x100..0x103 on cycles 1-4; memory_response in cycle 5 only; read_data=0x44332211.
- LB/LBU: option 000 then 100, byte 0x80 -> read_data 0xFFFFFF80, then 0x00000080. LH with 0x34,0x92 -> 0xFFFF9234.
- SH: write_data 0xDEADBEEF, option 001, address 0x7 -> two beats, bus_we=1, (0x7,0xEF) then (0x8,0xBE); read_data unchanged.
- Wait/handshake: WAIT_STATES=2, bus_ready low for 3 cycles on beat 0 -> bus_valid held with stable address; response cycle = 1+4*3+3 = 16.
- Reset and wrap: assert rst_n low during beat 2 -> outputs 0 asynchronously and no response. Then word write at address 0xFFFFFFFE -> bus_addr 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus_ready stuck low on a read -> response 8 cycles after beat entry, bus_error=1, read_data=0xFFFFFFFF. Next request completes normally with bus_error=0.
